// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: forwarding selects, hazard code bit positions,
// bubble opcode and the ID/EX stall FSM state type.
package riscv_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    localparam int HZ_SRC1 = 0;
    localparam int HZ_SRC2 = 1;
    localparam int HZ_LOAD = 2;

    localparam logic [6:0] OP_BUBBLE = 7'd0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_decode.sv
// Maps the two hazard codes onto per-operand forwarding selects;
// distance 1 (EX/MEM) wins over distance 2 (MEM/WB).
module fwd_decode
    import riscv_pkg::*;
(
    input  logic       is_hazard1,
    input  logic [2:0] hazard_reg1,
    input  logic       is_hazard2,
    input  logic [2:0] hazard_reg2,
    output logic [1:0] fwd_sel1,
    output logic [1:0] fwd_sel2
);

    // The load flag only matters for stalling, which the parent handles.
    logic unused_load_bits;
    assign unused_load_bits = &{1'b0, hazard_reg1[HZ_LOAD], hazard_reg2[HZ_LOAD]};

    always_comb begin
        fwd_sel1 = FWD_REGFILE;
        if (is_hazard1 && hazard_reg1[HZ_SRC1])
            fwd_sel1 = FWD_EXMEM;
        else if (is_hazard2 && hazard_reg2[HZ_SRC1])
            fwd_sel1 = FWD_MEMWB;
    end

    always_comb begin
        fwd_sel2 = FWD_REGFILE;
        if (is_hazard1 && hazard_reg1[HZ_SRC2])
            fwd_sel2 = FWD_EXMEM;
        else if (is_hazard2 && hazard_reg2[HZ_SRC2])
            fwd_sel2 = FWD_MEMWB;
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with one-cycle load-use stall, flush and forwarding selects.
// state | meaning: RUN = normal capture, load-use may stall | STALL = bubble issued, capture held ID next
module id_ex_reg
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [6:0]       id_op,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             is_hazard1,
    input  logic [2:0]       hazard_reg1,
    input  logic             is_hazard2,
    input  logic [2:0]       hazard_reg2,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [6:0]       ex_op,
    output logic [4:0]       ex_rd,
    output logic [XLEN-1:0]  ex_src1,
    output logic [XLEN-1:0]  ex_src2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc,
    output logic [1:0]       ex_fwd_sel1,
    output logic [1:0]       ex_fwd_sel2,
    output logic [CNT_W-1:0] stall_count
);

    state_t     state, state_nxt;
    logic       load_use;
    logic [1:0] fwd_sel1, fwd_sel2;

    assign load_use = id_valid && is_hazard1 && hazard_reg1[HZ_LOAD];

    fwd_decode u_fwd_decode (
        .is_hazard1  (is_hazard1),
        .hazard_reg1 (hazard_reg1),
        .is_hazard2  (is_hazard2),
        .hazard_reg2 (hazard_reg2),
        .fwd_sel1    (fwd_sel1),
        .fwd_sel2    (fwd_sel2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_RUN;
        if (!flush && state == ST_RUN && load_use)
            state_nxt = ST_STALL;
    end

    // Gated by rst_n so the upstream freeze never sees a stall during reset.
    always_comb begin
        stall = rst_n && (state == ST_RUN) && load_use && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_op       <= '0;
            ex_rd       <= '0;
            ex_src1     <= '0;
            ex_src2     <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
            ex_fwd_sel1 <= FWD_REGFILE;
            ex_fwd_sel2 <= FWD_REGFILE;
        end else if (flush || stall || !id_valid) begin
            ex_valid    <= 1'b0;
            ex_op       <= OP_BUBBLE;
            ex_rd       <= '0;
            ex_src1     <= '0;
            ex_src2     <= '0;
            ex_imm      <= '0;
            ex_pc       <= '0;
            ex_fwd_sel1 <= FWD_REGFILE;
            ex_fwd_sel2 <= FWD_REGFILE;
        end else begin
            ex_valid    <= 1'b1;
            ex_op       <= id_op;
            ex_rd       <= id_rd;
            ex_src1     <= id_rs1_data;
            ex_src2     <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_pc       <= id_pc;
            ex_fwd_sel1 <= fwd_sel1;
            ex_fwd_sel2 <= fwd_sel2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall && stall_count != {CNT_W{1'b1}})
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg; a second narrow-counter instance covers saturation.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [6:0]  id_op;
    logic [4:0]  id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        is_hazard1, is_hazard2, flush;
    logic [2:0]  hazard_reg1, hazard_reg2;
    logic        stall, ex_valid;
    logic [6:0]  ex_op;
    logic [4:0]  ex_rd;
    logic [31:0] ex_src1, ex_src2, ex_imm, ex_pc;
    logic [1:0]  ex_fwd_sel1, ex_fwd_sel2;
    logic [15:0] stall_count;

    logic        rst_n_s;
    logic        stall_s, ex_valid_s;
    logic [6:0]  ex_op_s;
    logic [4:0]  ex_rd_s;
    logic [31:0] ex_src1_s, ex_src2_s, ex_imm_s, ex_pc_s;
    logic [1:0]  ex_fwd_sel1_s, ex_fwd_sel2_s;
    logic [3:0]  stall_count_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .is_hazard1(is_hazard1), .hazard_reg1(hazard_reg1),
        .is_hazard2(is_hazard2), .hazard_reg2(hazard_reg2), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_fwd_sel1(ex_fwd_sel1), .ex_fwd_sel2(ex_fwd_sel2), .stall_count(stall_count)
    );

    // Permanent load-use stimulus: alternates stall / capture every cycle.
    id_ex_reg #(.XLEN(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n_s), .id_valid(1'b1), .id_op(7'h03), .id_rd(5'd1),
        .id_rs1_data(32'd1), .id_rs2_data(32'd2), .id_imm(32'd3), .id_pc(32'h40),
        .is_hazard1(1'b1), .hazard_reg1(3'b101),
        .is_hazard2(1'b0), .hazard_reg2(3'b000), .flush(1'b0),
        .stall(stall_s), .ex_valid(ex_valid_s), .ex_op(ex_op_s), .ex_rd(ex_rd_s),
        .ex_src1(ex_src1_s), .ex_src2(ex_src2_s), .ex_imm(ex_imm_s), .ex_pc(ex_pc_s),
        .ex_fwd_sel1(ex_fwd_sel1_s), .ex_fwd_sel2(ex_fwd_sel2_s), .stall_count(stall_count_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic h1, input logic [2:0] c1,
                         input logic h2, input logic [2:0] c2, input logic fl);
        id_valid    = v;
        id_pc       = pc;
        is_hazard1  = h1;
        hazard_reg1 = c1;
        is_hazard2  = h2;
        hazard_reg2 = c2;
        flush       = fl;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rst_n_s = 1'b0;
        id_op = 7'h33; id_rd = 5'd3;
        id_rs1_data = 32'd5; id_rs2_data = 32'd7; id_imm = 32'd9;
        // load-use pattern present during reset must not stall
        drive(1'b1, 32'h100, 1'b1, 3'b101, 1'b0, 3'b000, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_count", stall_count, 16'd0);
        step();
        chk("rst_pc_held", ex_pc, 32'h0);

        drive(1'b1, 32'h100, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("nohz_stall", stall, 1'b0);
        step();
        chk("nohz_valid", ex_valid, 1'b1);
        chk("nohz_pc", ex_pc, 32'h100);
        chk("nohz_src1", ex_src1, 32'd5);
        chk("nohz_src2", ex_src2, 32'd7);
        chk("nohz_op", ex_op, 7'h33);
        chk("nohz_rd", ex_rd, 5'd3);
        chk("nohz_sels", {ex_fwd_sel1, ex_fwd_sel2}, 4'b0000);

        drive(1'b1, 32'h104, 1'b1, 3'b001, 1'b1, 3'b011, 1'b0);
        chk("mix_stall", stall, 1'b0);
        step();
        chk("mix_sel1", ex_fwd_sel1, 2'b01);
        chk("mix_sel2", ex_fwd_sel2, 2'b10);

        drive(1'b1, 32'h108, 1'b1, 3'b011, 1'b1, 3'b011, 1'b0);
        step();
        chk("prio_sels", {ex_fwd_sel1, ex_fwd_sel2}, 4'b0101);

        drive(1'b0, 32'h10c, 1'b1, 3'b011, 1'b1, 3'b011, 1'b0);
        step();
        chk("inv_valid", ex_valid, 1'b0);
        chk("inv_sels", {ex_fwd_sel1, ex_fwd_sel2}, 4'b0000);

        // load-use: one stall cycle then capture with distance-2 forward
        drive(1'b1, 32'h200, 1'b1, 3'b101, 1'b0, 3'b000, 1'b0);
        chk("lu_stall", stall, 1'b1);
        step();
        chk("lu_bubble_valid", ex_valid, 1'b0);
        chk("lu_bubble_op", ex_op, 7'h00);
        chk("lu_count", stall_count, 16'd1);
        drive(1'b1, 32'h200, 1'b0, 3'b000, 1'b1, 3'b001, 1'b0);
        chk("lu_stall_drop", stall, 1'b0);
        step();
        chk("lu_cap_valid", ex_valid, 1'b1);
        chk("lu_cap_sel1", ex_fwd_sel1, 2'b10);
        chk("lu_cap_pc", ex_pc, 32'h200);
        chk("lu_count_hold", stall_count, 16'd1);

        // load bit is ignored while in STALL
        drive(1'b1, 32'h300, 1'b1, 3'b101, 1'b0, 3'b000, 1'b0);
        step();
        chk("st_count", stall_count, 16'd2);
        chk("st_hold_stall", stall, 1'b0);
        step();
        chk("st_cap_valid", ex_valid, 1'b1);
        chk("st_cap_sel1", ex_fwd_sel1, 2'b01);
        chk("st_count_hold", stall_count, 16'd2);

        // flush beats load-use in the same cycle
        drive(1'b1, 32'h400, 1'b1, 3'b101, 1'b0, 3'b000, 1'b1);
        chk("fl_stall", stall, 1'b0);
        step();
        chk("fl_valid", ex_valid, 1'b0);
        chk("fl_count", stall_count, 16'd2);
        drive(1'b1, 32'h404, 1'b1, 3'b101, 1'b0, 3'b000, 1'b0);
        chk("fl_run_stall", stall, 1'b1);
        step();
        chk("fl_count2", stall_count, 16'd3);

        // flush while in STALL drops the held instruction
        drive(1'b1, 32'h404, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1);
        step();
        chk("fls_valid", ex_valid, 1'b0);
        drive(1'b1, 32'h500, 1'b1, 3'b101, 1'b0, 3'b000, 1'b0);
        chk("fls_run_stall", stall, 1'b1);
        step();
        chk("fls_count", stall_count, 16'd4);

        // async reset between edges while in STALL
        rst_n = 1'b0;
        #1;
        chk("ar_valid", ex_valid, 1'b0);
        chk("ar_count", stall_count, 16'd0);
        chk("ar_pc", ex_pc, 32'h0);
        chk("ar_stall", stall, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("ar_rel_stall", stall, 1'b1);
        step();
        chk("ar_rel_count", stall_count, 16'd1);
        chk("ar_rel_valid", ex_valid, 1'b0);

        // saturation on the 4-bit counter instance
        drive(1'b0, 32'h0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
        rst_n_s = 1'b1;
        #1;
        for (int i = 1; i <= 27; i++) step();
        chk("sat_14", stall_count_s, 4'd14);
        step(); step();
        chk("sat_15", stall_count_s, 4'hF);
        for (int i = 0; i < 9; i++) step();
        chk("sat_hold", stall_count_s, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
